spi_slave_shift_engine: RTL and testbench
=========================================

// Module: spi_slave_shift_engine
// PURPOSE
//  SPI slave endpoint: the far end of the SPI master core's link. Lives in the
//  PCLK domain and oversamples sclk/ss/mosi; drives miso. Supports all four
//  CPOL/CPHA modes and MSB/LSB-first framing. Parallel TX/RX handshakes toward
//  the local host. Used as the bench-side peer for the master and as a
//  standalone slave IP.
// PARAMETERS
//  DATA_W      8      frame width in bits (>=2)
//  IDLE_TX     8'hFF  word shifted out when TX buffer is empty at frame start
// PORTS
//  PCLK        in   1       system clock (only clock)
//  PRESET      in   1       asynchronous, active-high reset
//  spe         in   1       slave enable; 0 = ignore bus, miso_oe=0
//  cpol        in   1       clock idle level
//  cpha        in   1       0: sample leading edge; 1: sample trailing edge
//  lsbfe       in   1       1 = LSB first, 0 = MSB first
//  tx_data     in   DATA_W  word for next frame
//  tx_valid    in   1       tx_data offered
//  tx_ready    out  1       TX buffer empty (accepts when tx_valid&tx_ready)
//  rx_data     out  DATA_W  last completed received frame
//  rx_valid    out  1       rx_data holds an unread frame
//  rx_ack      in   1       host consumes rx_data; clears rx_valid
//  rx_overrun  out  1       1-cycle pulse: frame completed while rx_valid=1
//  tx_underrun out  1       1-cycle pulse: frame started with TX buffer empty
//  busy        out  1       frame in progress
//  sclk        in   1       SPI clock from master (async to PCLK)
//  ss          in   1       slave select, active low (async)
//  mosi        in   1       serial data in (async)
//  miso        out  1       serial data out
//  miso_oe     out  1       miso output enable (1 only while selected & spe)
// BEHAVIOUR
//  - Reset: tx_ready=1, rx_data=0, rx_valid=0, pulses=0, busy=0, miso=0,
//    miso_oe=0, state=IDLE, bit counter=0, sync flops to 1,cpol,0.
//  - sclk, ss, mosi pass 2-flop synchronizers; edge detect on 3rd flop.
//    Edge pulse is high on PCLK edge #3 after the pin change. Requirement:
//    sclk high/low phases >= 3 PCLK periods; bench and master enforce.
//  - Leading edge = sclk leaves cpol level; trailing = returns to cpol.
//  - FSM IDLE -> LOAD -> XFER -> IDLE:
//    IDLE: wait ss_sync falling with spe=1. LOAD (1 cycle): shift reg <=
//      TX buffer (tx_ready->1) or IDLE_TX (+tx_underrun pulse); bit cnt=0;
//      miso_oe=1; busy=1. cpha=0: first bit driven on miso in LOAD.
//    XFER: cpha=0: sample mosi on leading, shift out next bit on trailing.
//      cpha=1: shift out on leading (first bit on first leading), sample
//      on trailing. After DATA_W samples: rx_data<=frame next cycle,
//      rx_valid<=1 (rx_overrun pulse if already 1; data overwritten);
//      if ss still low -> LOAD (back-to-back frames), else IDLE.
//  - Sample-to-rx_valid: rx_valid rises 4 PCLK edges after final sampling
//    sclk pin edge.
//  - lsbfe selects shift direction for both TX and RX; rx_data is always
//    presented in natural bit order.
//  - ss rises mid-frame: abort -> IDLE next cycle; partial frame discarded,
//    no rx_valid, TX word already loaded is lost; miso_oe=0, busy=0.
//  - spe falls: same as ss abort. cpol/cpha/lsbfe sampled only in IDLE.
//  - rx_ack and completion in same cycle: rx_valid stays 1, no overrun.
//  - tx_valid accepted any state; loaded word waits for next LOAD.
//  - Ignore sclk edges in IDLE/LOAD. Bit counter width clog2(DATA_W+1).
// STRUCTURE
//  spi_pkg: state enum {IDLE,LOAD,XFER}, SYNC_STAGES=2 constant.
//  Sub-module spi_sync_edge: 2-flop sync + rise/fall pulse, instantiated
//  for sclk, ss (mosi uses sync only). FSM/shift/handshake stay in top.
// TESTING
//  1 Mode0 MSB, tx_data=8'hA5 preloaded, master sends 8'h3C -> miso bits
//    1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1 4 cycles after 8th edge.
//  2 Modes 1,2,3 each with lsbfe=1, tx 8'h81, rx 8'h5A -> bit order LSB
//    first on miso; rx_data=8'h5A for every mode.
//  3 ss low for 3 back-to-back frames, no rx_ack, only 1 tx word -> 2
//    rx_overrun pulses, frames 2-3 send 8'hFF, 2 tx_underrun pulses.
//  4 ss high after 4 bits -> no rx_valid, busy=0, miso_oe=0 next cycles;
//    following full frame received correctly.
//  5 PRESET pulsed mid-frame -> all outputs at reset values same cycle;
//    next frame after release correct. spe=0 -> miso_oe stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave shift engine.
package spi_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StXfer
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous pin plus a delay flop for rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RstVal}};
      dly_q  <= RstVal;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/spi_slave_shift_engine.sv
// SPI slave endpoint oversampling sclk/ss/mosi in the PCLK domain; all four
// CPOL/CPHA modes, MSB/LSB-first framing, parallel TX/RX handshakes.
module spi_slave_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] IDLE_TX = {DATA_W{1'b1}}
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic              cfg_cpol_q, cfg_cpol_d;
  logic              cfg_cpha_q, cfg_cpha_d;
  logic              cfg_lsbfe_q, cfg_lsbfe_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              busy_q, busy_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  logic sclk_norm, sclk_lvl, sclk_lead, sclk_trail;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_s, sample_en, shift_en;
  logic unused_sync;

  // Normalising sclk against the latched cpol makes "rise" the leading edge
  // in every mode; the sync flops reset to 0, i.e. to the idle level.
  assign sclk_norm = sclk ^ cfg_cpol_q;

  spi_sync_edge #(
    .RstVal (1'b0)
  ) u_sclk_sync (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .d_i     (sclk_norm),
    .level_o (sclk_lvl),
    .rise_o  (sclk_lead),
    .fall_o  (sclk_trail)
  );

  spi_sync_edge #(
    .RstVal (1'b1)
  ) u_ss_sync (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .d_i     (ss),
    .level_o (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  assign unused_sync = ^{sclk_lvl, ss_rise};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  function automatic logic tx_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  always_comb begin
    state_d       = state_q;
    cfg_cpol_d    = cfg_cpol_q;
    cfg_cpha_d    = cfg_cpha_q;
    cfg_lsbfe_d   = cfg_lsbfe_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    miso_d        = miso_q;
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sample_en     = 1'b0;
    shift_en      = 1'b0;

    if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cfg_cpol_d  = cpol;
        cfg_cpha_d  = cpha;
        cfg_lsbfe_d = lsbfe;
        if (spe && ss_fall) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!spe || ss_lvl) begin
          state_d = StIdle;
        end else begin
          state_d   = StXfer;
          bit_cnt_d = '0;
          if (tx_full_q) begin
            tx_sh_d   = tx_buf_q;
            tx_full_d = 1'b0;
          end else begin
            tx_sh_d       = IDLE_TX;
            tx_underrun_d = 1'b1;
          end
          if (!cfg_cpha_q) begin
            miso_d = tx_bit(tx_sh_d, cfg_lsbfe_q);
          end
        end
      end
      StXfer: begin
        if (!spe) begin
          state_d = StIdle;
        end else if (bit_cnt_q == CntW'(DATA_W)) begin
          rx_data_d    = rx_sh_q;
          rx_valid_d   = 1'b1;
          rx_overrun_d = rx_valid_q & ~rx_ack;
          state_d      = ss_lvl ? StIdle : StLoad;
        end else if (ss_lvl) begin
          state_d = StIdle;
        end else begin
          // In cpha=0 a trailing edge before the first sample belongs to the
          // previous frame and must not disturb the bit already on miso.
          sample_en = cfg_cpha_q ? sclk_trail : sclk_lead;
          shift_en  = cfg_cpha_q ? sclk_lead : (sclk_trail && (bit_cnt_q != '0));
          if (sample_en) begin
            rx_sh_d   = rx_shift(rx_sh_q, mosi_s, cfg_lsbfe_q);
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (shift_en) begin
            tx_sh_d = tx_shift(tx_sh_q, cfg_lsbfe_q);
            miso_d  = cfg_cpha_q ? tx_bit(tx_sh_q, cfg_lsbfe_q) : tx_bit(tx_sh_d, cfg_lsbfe_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d    = (state_d != StIdle);
    miso_oe_d = busy_d;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= StIdle;
      cfg_cpol_q    <= 1'b0;
      cfg_cpha_q    <= 1'b0;
      cfg_lsbfe_q   <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      bit_cnt_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      busy_q        <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      mosi_sync_q   <= '0;
    end else begin
      state_q       <= state_d;
      cfg_cpol_q    <= cfg_cpol_d;
      cfg_cpha_q    <= cfg_cpha_d;
      cfg_lsbfe_q   <= cfg_lsbfe_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      busy_q        <= busy_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      mosi_sync_q   <= mosi_sync_d;
    end
  end

  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;
  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Directed bench: acts as SPI master, checks frames, handshakes and corner cases.
module tb_spi_slave_shift_engine;

  localparam int HALF = 4;

  logic       PCLK, PRESET;
  logic       spe, cpol, cpha, lsbfe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ack, rx_overrun, tx_underrun, busy;
  logic       sclk, ss, mosi, miso, miso_oe;

  int n_checks = 0;
  int n_err    = 0;
  int ovr_cnt  = 0;
  int und_cnt  = 0;

  spi_slave_shift_engine #(
    .DATA_W  (8),
    .IDLE_TX (8'hFF)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .spe         (spe),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsbfe       (lsbfe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .busy        (busy),
    .sclk        (sclk),
    .ss          (ss),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) begin
    if (rx_overrun) ovr_cnt++;
    if (tx_underrun) und_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_seq;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [8];

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol  = pol;
    cpha  = pha;
    lsbfe = lsb;
    sclk  = pol;
    cyc(10);
  endtask

  // seq collects miso in wire order: first bit on the wire lands in bit 7.
  task automatic frame_bits(input logic [7:0] mo, input int nbits, input bit chk_lat,
                            output logic [7:0] seq);
    logic [7:0] mo_w;
    for (int j = 0; j < 8; j++) mo_w[7-j] = lsbfe ? mo[j] : mo[7-j];
    seq = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo_w[7-i];
        cyc(HALF);
        seq[7-i] = miso;
        sclk = ~cpol;
        if (chk_lat && i == nbits - 1) begin
          cyc(3);
          check("rx_valid_lat3", rx_valid, 0);
          cyc(1);
          check("rx_valid_lat4", rx_valid, 1);
        end else begin
          cyc(HALF);
        end
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo_w[7-i];
        cyc(HALF);
        seq[7-i] = miso;
        sclk = cpol;
        cyc(HALF);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {tx_ready, rx_valid, rx_data, busy, miso, miso_oe, rx_overrun, tx_underrun},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    logic [7:0] seq, seq1, seq2, seq3;
    int         ovr0, und0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h0F, 8'h1E, 8'hF0, 8'h1E};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h2C, 8'hC3, 8'h34, 8'hC3};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h3A, 8'h96, 8'h3A, 8'h96};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 8'h80, 8'h80};

    PRESET = 1'b1; spe = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
    sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    cyc(2);
    check_reset_outputs("reset_state");
    PRESET = 1'b0;
    cyc(5);

    for (int i = 0; i < 8; i++) begin
      set_mode(vecs[i].cpol, vecs[i].cpha, vecs[i].lsbfe);
      send_tx(vecs[i].tx);
      check($sformatf("v%0d_tx_held", i), tx_ready, 0);
      ss = 1'b0;
      cyc(8);
      check($sformatf("v%0d_busy_on", i), {busy, miso_oe}, 2'b11);
      frame_bits(vecs[i].mo, 8, (i == 0), seq);
      cyc(HALF);
      ss = 1'b1;
      cyc(6);
      check($sformatf("v%0d_rx_valid", i), rx_valid, 1);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_miso_seq", i), seq, vecs[i].exp_seq);
      check($sformatf("v%0d_idle_out", i), {tx_ready, busy, miso_oe}, 3'b100);
      ack_rx();
      check($sformatf("v%0d_ack", i), rx_valid, 0);
    end

    // Three back-to-back frames, one TX word, no rx_ack.
    set_mode(1'b0, 1'b0, 1'b0);
    send_tx(8'h11);
    ovr0 = ovr_cnt;
    und0 = und_cnt;
    ss = 1'b0;
    cyc(8);
    frame_bits(8'hC1, 8, 1'b0, seq1);
    frame_bits(8'h22, 8, 1'b0, seq2);
    frame_bits(8'h33, 8, 1'b0, seq3);
    cyc(1);
    check("b2b_overruns", ovr_cnt - ovr0, 2);
    check("b2b_underruns", und_cnt - und0, 2);
    ss = 1'b1;
    cyc(6);
    check("b2b_seq1", seq1, 8'h11);
    check("b2b_seq2", seq2, 8'hFF);
    check("b2b_seq3", seq3, 8'hFF);
    check("b2b_rx_last", {rx_valid, rx_data}, {1'b1, 8'h33});
    ack_rx();

    // ss abort after 4 bits, then a clean frame.
    send_tx(8'h5C);
    ss = 1'b0;
    cyc(8);
    frame_bits(8'hF0, 4, 1'b0, seq);
    ss = 1'b1;
    cyc(4);
    check("abort_idle", {rx_valid, busy, miso_oe, tx_ready}, 4'b0001);
    cyc(4);
    send_tx(8'h6B);
    ss = 1'b0;
    cyc(8);
    frame_bits(8'h9D, 8, 1'b0, seq);
    cyc(HALF);
    ss = 1'b1;
    cyc(6);
    check("post_abort_rx", {rx_valid, rx_data}, {1'b1, 8'h9D});
    check("post_abort_seq", seq, 8'h6B);
    ack_rx();

    // Disabled slave ignores a whole frame.
    spe = 1'b0;
    ss = 1'b0;
    cyc(8);
    check("spe0_oe", {busy, miso_oe}, 2'b00);
    frame_bits(8'h42, 8, 1'b0, seq);
    cyc(HALF);
    check("spe0_no_rx", {rx_valid, miso_oe}, 2'b00);
    ss = 1'b1;
    cyc(4);
    spe = 1'b1;
    cyc(4);

    // Asynchronous reset mid-frame.
    send_tx(8'h77);
    ss = 1'b0;
    cyc(8);
    frame_bits(8'hAA, 3, 1'b0, seq);
    PRESET = 1'b1;
    #1;
    check_reset_outputs("preset_mid_frame");
    ss = 1'b1;
    sclk = cpol;
    cyc(2);
    PRESET = 1'b0;
    cyc(6);
    send_tx(8'hE4);
    ss = 1'b0;
    cyc(8);
    frame_bits(8'h47, 8, 1'b0, seq);
    cyc(HALF);
    ss = 1'b1;
    cyc(6);
    check("post_reset_rx", {rx_valid, rx_data}, {1'b1, 8'h47});
    check("post_reset_seq", seq, 8'hE4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
